// File: rtl/even_sequence_checker.sv
// even_sequence_checker: predicts the next value of an even-step sequence generator,
// locks after a run of correct samples and then flags, counts and marks deviations and wraps.
module even_sequence_checker #(
    parameter int WIDTH    = 4,
    parameter int STEP     = 2,
    parameter int LOCK_CNT = 3,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] seq_in,
    input  logic             run_in,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [WIDTH-1:0] exp_out,
    output logic [ERRW-1:0]  err_count
);
    typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;
    state_t state, state_nx;
    logic [3:0] match_cnt, match_cnt_nx;
    logic wrap_pend, hit, err_nx, wrap_nx;
    logic [WIDTH:0] sum;
    assign sum = {1'b0, seq_in} + (WIDTH+1)'(STEP);
    assign hit = seq_in == exp_out;
    always_comb begin
        state_nx = state;
        match_cnt_nx = match_cnt;
        err_nx = 1'b0;
        wrap_nx = 1'b0;
        case (state)
            SEARCH: begin
                state_nx = seq_in[0] ? SEARCH : LOCKING;
                match_cnt_nx = '0;
            end
            LOCKING: begin
                match_cnt_nx = hit ? match_cnt + 4'd1 : '0;
                state_nx = !hit ? SEARCH : (match_cnt + 4'd1 == 4'(LOCK_CNT)) ? LOCKED : LOCKING;
            end
            LOCKED: begin
                err_nx = !hit;
                wrap_nx = hit && seq_in == '0 && wrap_pend;
                state_nx = hit ? LOCKED : SEARCH;
                match_cnt_nx = hit ? match_cnt : '0;
            end
            default: begin
                state_nx = SEARCH;
                match_cnt_nx = '0;
            end
        endcase
    end
    // wrap_pend marks that the current prediction came from rolling over the top value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SEARCH;
            match_cnt <= '0;
            locked <= 1'b0;
            err <= 1'b0;
            wrap <= 1'b0;
            wrap_pend <= 1'b0;
            exp_out <= '0;
            err_count <= '0;
        end else begin
            state <= state_nx;
            match_cnt <= match_cnt_nx;
            locked <= state_nx == LOCKED;
            err <= err_nx;
            wrap <= wrap_nx;
            wrap_pend <= run_in && sum[WIDTH];
            exp_out <= run_in ? sum[WIDTH-1:0] : seq_in;
            if (err_nx && err_count != '1) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_even_sequence_checker.sv
// tb_even_sequence_checker: table vectors, directed corner sequences and random stimulus
// against a behavioural model; a second instance with a 2-bit error counter checks saturation.
module tb_even_sequence_checker;
    logic clk = 1'b0, rstn = 1'b0, run_in = 1'b0;
    logic [3:0] seq_in = 4'd0;
    logic locked, err, wrap, locked2, err2, wrap2;
    logic [3:0] exp_out, exp_out2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    int checks = 0, errors = 0;
    int m_exp, m_streak, m_cnt1, m_cnt2;
    bit m_locked, m_err, m_wrap, m_pend;

    even_sequence_checker dut (.clk(clk), .rstn(rstn), .seq_in(seq_in), .run_in(run_in),
        .locked(locked), .err(err), .wrap(wrap), .exp_out(exp_out), .err_count(err_count));
    even_sequence_checker #(.ERRW(2)) dut2 (.clk(clk), .rstn(rstn), .seq_in(seq_in), .run_in(run_in),
        .locked(locked2), .err(err2), .wrap(wrap2), .exp_out(exp_out2), .err_count(err_count2));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s;
        logic r, l, e, w;
        logic [3:0] x;
        logic [7:0] c;
    } vec_t;
    vec_t tbl [20];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_exp = 0; m_streak = -1; m_cnt1 = 0; m_cnt2 = 0;
        m_locked = 0; m_err = 0; m_wrap = 0; m_pend = 0;
    endtask

    task automatic model_edge(input int s, input bit r);
        bit hit;
        hit = (s == m_exp);
        m_err = 0;
        m_wrap = 0;
        if (m_locked) begin
            if (hit) m_wrap = (s == 0) && m_pend;
            else begin
                m_err = 1;
                m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                m_locked = 0;
                m_streak = -1;
            end
        end else if (m_streak < 0) begin
            if (s % 2 == 0) m_streak = 0;
        end else if (hit) begin
            m_streak++;
            if (m_streak == 3) m_locked = 1;
        end else m_streak = -1;
        m_pend = r && (s + 2 > 15);
        m_exp = r ? (s + 2) % 16 : s;
    endtask

    task automatic compare_model();
        check("locked", int'(locked), int'(m_locked));
        check("err", int'(err), int'(m_err));
        check("wrap", int'(wrap), int'(m_wrap));
        check("exp_out", int'(exp_out), m_exp);
        check("err_count", int'(err_count), m_cnt1);
        check("err_count2", int'(err_count2), m_cnt2);
    endtask

    task automatic step(input int s, input bit r);
        seq_in = 4'(s);
        run_in = r;
        @(posedge clk);
        #1;
        model_edge(s, r);
        compare_model();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
    endtask

    initial begin
        model_reset();
        // T1: reset holds everything at zero
        seq_in = 4'd6;
        run_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_locked", int'(locked), 0);
            check("rst_err", int'(err), 0);
            check("rst_exp", int'(exp_out), 0);
            check("rst_cnt", int'(err_count), 0);
        end
        rstn = 1'b1;
        // T2/T4: lock, wrap, error, relock
        tbl[0]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  8'd0};
        tbl[1]  = '{4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  8'd0};
        tbl[2]  = '{4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 4'd6,  8'd0};
        tbl[3]  = '{4'd6,  1'b1, 1'b1, 1'b0, 1'b0, 4'd8,  8'd0};
        tbl[4]  = '{4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 8'd0};
        tbl[5]  = '{4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 8'd0};
        tbl[6]  = '{4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 4'd14, 8'd0};
        tbl[7]  = '{4'd14, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  8'd0};
        tbl[8]  = '{4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  8'd0};
        tbl[9]  = '{4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 4'd4,  8'd0};
        tbl[10] = '{4'd4,  1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  8'd0};
        tbl[11] = '{4'd8,  1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 8'd1};
        tbl[12] = '{4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12, 8'd1};
        tbl[13] = '{4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 8'd1};
        tbl[14] = '{4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  8'd1};
        tbl[15] = '{4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  8'd1};
        tbl[16] = '{4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  8'd1};
        tbl[17] = '{4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  8'd1};
        tbl[18] = '{4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 4'd4,  8'd1};
        tbl[19] = '{4'd4,  1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  8'd1};
        for (int i = 0; i < 20; i++) begin
            step(int'(tbl[i].s), tbl[i].r);
            check("tbl_locked", int'(locked), int'(tbl[i].l));
            check("tbl_err", int'(err), int'(tbl[i].e));
            check("tbl_wrap", int'(wrap), int'(tbl[i].w));
            check("tbl_exp", int'(exp_out), int'(tbl[i].x));
            check("tbl_cnt", int'(err_count), int'(tbl[i].c));
        end
        // T3: hold at 8 for three cycles, then resume
        step(6, 1);
        for (int i = 0; i < 3; i++) step(8, 0);
        step(8, 1);
        step(10, 1);
        check("hold_locked", int'(locked), 1);
        check("hold_cnt", int'(err_count), 1);
        // T5: odd values in SEARCH, then repeated LOCKED misses saturate the 2-bit counter
        do_reset();
        step(3, 1);
        step(7, 1);
        step(5, 0);
        check("odd_err", int'(err), 0);
        for (int k = 0; k < 5; k++) begin
            for (int v = 0; v < 8; v += 2) step(v, 1);
            step(9, 1);
            check("miss_err", int'(err), 1);
        end
        check("sat_cnt2", int'(err_count2), 3);
        check("sat_cnt", int'(err_count), 5);
        // T6: async reset between edges while LOCKED at 12
        for (int v = 0; v <= 12; v += 2) step(v, 1);
        check("pre_locked", int'(locked), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_locked", int'(locked), 0);
        check("async_cnt", int'(err_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(14, 1);
        step(0, 1);
        check("post_rst_err", int'(err), 0);
        // Randomized, mostly-coherent sequences
        do_reset();
        for (int i = 0; i < 500; i++) begin
            bit r;
            int s;
            r = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 99) < 8) ? int'($urandom_range(0, 15)) : m_exp;
            step(s, r);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
